// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART frame parser.
//   byte_t      - 8-bit data byte
//   state_t     - frame parser FSM states
//   SOF_DEFAULT - default start-of-frame marker byte
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        EMIT    = 3'd4
    } state_t;

    localparam byte_t SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: DEPTH x 8 payload store, no reset.
//   clk   in  - clock
//   we    in  - write enable (synchronous write)
//   waddr in  - write address
//   wdata in  - write data
//   raddr in  - read address (asynchronous read)
//   rdata out - read data
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);

    byte_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles SOF/LEN/payload/CHK frames from a UART byte
// receiver, buffers the payload and replays checksum-valid frames on a
// valid/ready byte stream.
//   clk, reset (async, active-high)
//   rx_data/rx_valid    in  - received byte and its single-cycle strobe
//   out_data/out_valid  out - payload stream (out_data is 0 when not valid)
//   out_ready           in  - downstream accept
//   out_last            out - final payload byte of the frame
//   frame_ok, err_*     out - single-cycle registered event pulses
//   busy                out - parser not in IDLE
//   dbg_state           out - current FSM state (encoding of state_t)
//
// Stream handshake: a byte transfers on every cycle where out_valid and
// out_ready are both high; while out_valid is high and out_ready low,
// out_data and out_last hold stable; out_valid never drops before the
// transfer happens.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter byte_t SOF            = SOF_DEFAULT,
    parameter int    MAX_LEN        = 16,
    parameter int    TIMEOUT_CYCLES = 1_100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       err_length,
    output logic       err_checksum,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int BW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO  = '0;
    localparam logic [TW-1:0] TCNT_ONE  = TW'(1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam byte_t         MAX_LEN_B = byte_t'(MAX_LEN);

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_len;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    byte_t         r_sum;
    logic [TW-1:0] r_tcnt;

    logic r_frame_ok, r_err_length, r_err_checksum, r_err_timeout, r_err_overrun;

    logic  w_frame_ok, w_err_length, w_err_checksum, w_err_timeout, w_err_overrun;
    logic  w_in_frame;
    logic  w_expire;
    logic  w_len_bad;
    logic  w_wr_last;
    logic  w_rd_last;
    logic  w_sum_match;
    logic  w_buf_we;
    logic  w_handshake;
    byte_t w_rdata;

    assign w_in_frame  = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHECK);
    assign w_expire    = (r_tcnt == TCNT_LAST);
    assign w_len_bad   = (rx_data == 8'h00) || (rx_data > MAX_LEN_B);
    assign w_wr_last   = (r_wr_idx == r_len - IDX_ONE);
    assign w_rd_last   = (r_rd_idx == r_len - IDX_ONE);
    assign w_sum_match = (rx_data == r_sum);
    assign w_handshake = (r_state == EMIT) && out_ready;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (BW)
    ) u_buf (
        .clk   (clk),
        .we    (w_buf_we),
        .waddr (r_wr_idx[BW-1:0]),
        .wdata (rx_data),
        .raddr (r_rd_idx[BW-1:0]),
        .rdata (w_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Inside a frame an arriving byte always takes
    // priority over an expiring inter-byte timer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (rx_valid && (rx_data == SOF)) w_state_next = LEN;
            end
            LEN: begin
                if (rx_valid)      w_state_next = w_len_bad ? IDLE : PAYLOAD;
                else if (w_expire) w_state_next = IDLE;
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    if (w_wr_last) w_state_next = CHECK;
                end else if (w_expire) begin
                    w_state_next = IDLE;
                end
            end
            CHECK: begin
                if (rx_valid)      w_state_next = w_sum_match ? EMIT : IDLE;
                else if (w_expire) w_state_next = IDLE;
            end
            EMIT: begin
                if (out_ready && w_rd_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic: stream outputs decode the current state, the w_* event
    // terms are registered below so every pulse lands one cycle after its
    // triggering byte (frame_ok therefore coincides with the first out_valid).
    always_comb begin
        out_valid      = (r_state == EMIT);
        out_data       = out_valid ? w_rdata : 8'h00;
        out_last       = out_valid && w_rd_last;
        busy           = (r_state != IDLE);
        dbg_state      = r_state;
        w_buf_we       = (r_state == PAYLOAD) && rx_valid;
        w_frame_ok     = (r_state == CHECK) && rx_valid && w_sum_match;
        w_err_checksum = (r_state == CHECK) && rx_valid && !w_sum_match;
        w_err_length   = (r_state == LEN) && rx_valid && w_len_bad;
        w_err_timeout  = w_in_frame && !rx_valid && w_expire;
        w_err_overrun  = (r_state == EMIT) && rx_valid;
    end

    assign frame_ok     = r_frame_ok;
    assign err_length   = r_err_length;
    assign err_checksum = r_err_checksum;
    assign err_timeout  = r_err_timeout;
    assign err_overrun  = r_err_overrun;

    // Datapath, timer and event pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len          <= '0;
            r_wr_idx       <= '0;
            r_rd_idx       <= '0;
            r_sum          <= '0;
            r_tcnt         <= '0;
            r_frame_ok     <= 1'b0;
            r_err_length   <= 1'b0;
            r_err_checksum <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            r_frame_ok     <= w_frame_ok;
            r_err_length   <= w_err_length;
            r_err_checksum <= w_err_checksum;
            r_err_timeout  <= w_err_timeout;
            r_err_overrun  <= w_err_overrun;

            if ((r_state == LEN) && rx_valid && !w_len_bad) begin
                r_len    <= rx_data[IW-1:0];
                r_sum    <= rx_data;
                r_wr_idx <= IDX_ZERO;
            end

            if (w_buf_we) begin
                r_sum    <= r_sum + rx_data;
                r_wr_idx <= r_wr_idx + IDX_ONE;
            end

            if (w_frame_ok) begin
                r_rd_idx <= IDX_ZERO;
            end else if (w_handshake) begin
                r_rd_idx <= r_rd_idx + IDX_ONE;
            end

            // Counts idle cycles inside a frame; IDLE/EMIT hold it at zero,
            // which also gives the clear on entry to LEN.
            if (w_in_frame && !rx_valid && !w_expire) begin
                r_tcnt <= r_tcnt + TCNT_ONE;
            end else begin
                r_tcnt <= '0;
            end
        end
    end

endmodule
